// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the accumulator/stack datapath.
// Strobes decode from State and the latched opcode; memory phases stall on MemReady and trap on timeout.
module multicycle_sequencer #(
   parameter int OPCODE_W = 6,
   parameter int TIMEOUT  = 16,
   parameter int COUNT_W  = 16
) (
   input  logic                CLK,
   input  logic                Reset,
   input  logic                Run,
   input  logic [OPCODE_W-1:0] Opcode,
   input  logic                FlagBit,
   input  logic                MemReady,
   output logic [2:0]          State,
   output logic                IRWrite,
   output logic                PCWrite,
   output logic [1:0]          PCSrc,
   output logic                RAWrite,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                SPWrite,
   output logic                WBEn,
   output logic                Halted,
   output logic                Trap,
   output logic                TrapCause,
   output logic [COUNT_W-1:0]  InstrCount
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      sIdle   = 3'd0,
      sFetch  = 3'd1,
      sDecode = 3'd2,
      sExec   = 3'd3,
      sMem    = 3'd4,
      sWb     = 3'd5,
      sHalt   = 3'd6,
      sTrap   = 3'd7
   } stateT;

   typedef enum logic [2:0] {
      clsAlu, clsRead, clsWrite, clsJump, clsSwap, clsIllegal
   } classT;

   stateT               state, nextState;
   logic [OPCODE_W-1:0] opReg;
   logic [WAIT_W-1:0]   waitCnt;
   classT               opClass;
   logic                retire;
   logic                timeoutTrap;
   logic                illegalTrap;
   logic                memWait;
   logic [31:0]         opVal;

   function automatic classT classify(input logic [31:0] v);
      if (v == 32'd0 || v >= 32'd40)               return clsIllegal;
      else if (v <= 32'd3)                         return clsWrite;
      else if (v <= 32'd7)                         return clsAlu;
      else if (v <= 32'd10)                        return clsRead;
      else if (v <= 32'd19)                        return clsJump;
      else if (v <= 32'd31)                        return clsAlu;
      else if (v <= 32'd33)                        return clsRead;
      else if (v <= 32'd38)                        return clsWrite;
      else                                         return clsSwap;
   endfunction

   assign opVal   = 32'(opReg);
   assign opClass = classify(opVal);
   assign State   = state;
   assign memWait = (state == sFetch || state == sMem) && !MemReady;

   always_comb begin
      nextState   = state;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCSrc       = 2'd0;
      RAWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      SPWrite     = 1'b0;
      WBEn        = 1'b0;
      Halted      = 1'b0;
      Trap        = 1'b0;
      retire      = 1'b0;
      timeoutTrap = 1'b0;
      illegalTrap = 1'b0;
      case (state)
         sIdle: if (Run) nextState = sFetch;
         sFetch: begin
            MemRead = 1'b1;
            if (MemReady) begin
               IRWrite   = 1'b1;
               PCWrite   = 1'b1;
               nextState = sDecode;
            end else if (waitCnt == WAIT_W'(TIMEOUT - 1)) begin
               timeoutTrap = 1'b1;
               nextState   = sTrap;
            end
         end
         sDecode: begin
            if (Opcode == '0) begin
               nextState = sHalt;
            end else if (classify(32'(Opcode)) == clsIllegal) begin
               illegalTrap = 1'b1;
               nextState   = sTrap;
            end else begin
               nextState = sExec;
            end
         end
         sExec: begin
            case (opClass)
               clsRead, clsWrite: nextState = sMem;
               clsJump: begin
                  PCSrc     = (opVal == 32'd17) ? 2'd2 : 2'd1;
                  // Only JCMP/JCMP@ are conditional on the comparison flag
                  PCWrite   = !(opVal == 32'd15 || opVal == 32'd16) || FlagBit;
                  RAWrite   = (opVal == 32'd18 || opVal == 32'd19);
                  retire    = 1'b1;
                  nextState = sFetch;
               end
               default: nextState = sWb;
            endcase
         end
         sMem: begin
            MemRead  = (opClass == clsRead);
            MemWrite = (opClass != clsRead);
            if (MemReady) begin
               SPWrite = (opVal >= 32'd1 && opVal <= 32'd3) || opVal == 32'd9 ||
                         opVal == 32'd10 || (opVal >= 32'd36 && opVal <= 32'd38);
               if (opClass == clsRead) begin
                  nextState = sWb;
               end else begin
                  retire    = 1'b1;
                  nextState = sFetch;
               end
            end else if (waitCnt == WAIT_W'(TIMEOUT - 1)) begin
               timeoutTrap = 1'b1;
               nextState   = sTrap;
            end
         end
         sWb: begin
            WBEn      = 1'b1;
            retire    = 1'b1;
            nextState = sFetch;
         end
         sHalt: begin
            Halted = 1'b1;
            if (Run) nextState = sFetch;
         end
         default: Trap = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state      <= sIdle;
         opReg      <= '0;
         waitCnt    <= '0;
         TrapCause  <= 1'b0;
         InstrCount <= '0;
      end else begin
         state   <= nextState;
         waitCnt <= memWait ? waitCnt + 1'b1 : '0;
         if (state == sDecode) opReg <= Opcode;
         if (timeoutTrap) TrapCause <= 1'b1;
         else if (illegalTrap) TrapCause <= 1'b0;
         if (retire && InstrCount != '1) InstrCount <= InstrCount + 1'b1;
      end
   end

endmodule
